smbus_event_scheduler: RTL
==========================

# smbus_event_scheduler

Shares the single SMBus event slot of the LTPI transmit frame among NUM_CH SMBus relay channels. Accepts one 4-bit `smbus_event_t` per channel with a valid/ready handshake and arbitrates round-robin. Holds the granted event in the slot for a class-dependent number of frame boundaries. For data-class events, keeps retransmitting until the matching echo arrives from the receive path or a frame-count timeout expires. Sits between the per-channel SMBus relay/echo logic and the LTPI frame builder.

## Interface
- NUM_CH, 4: number of requesting channels (2..8).
- REPEAT_DATA, 3: minimum frames for data_0/data_1/bit_rcv (DC-SCM 2.0 LTPI v1.1).
- REPEAT_CTRL, 1: frames for all other events.
- ECHO_TIMEOUT, 16: frames to wait in ST_WAIT_ECHO before error.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  grants new requests when high.
- frame_tick  in  1  one-cycle pulse; frame builder samples slot_event at this edge.
- req_valid  in  NUM_CH  per-channel request.
- req_event  in  4*NUM_CH  per-channel event; ch i at [4i+3:4i].
- req_ready  out  NUM_CH  one-hot accept, combinational.
- rx_echo_valid  in  1  received echo strobe.
- rx_echo_ch  in  $clog2(NUM_CH)  channel of received echo.
- rx_echo_event  in  4  received echo event.
- slot_valid  out  1  slot carries a scheduled event.
- slot_event  out  4  event for the frame slot.
- slot_ch  out  $clog2(NUM_CH)  owning channel.
- err  out  NUM_CH  sticky echo-timeout flags.
- err_clr  in  NUM_CH  write-1-clear for err.

## Operation
- States: ST_IDLE, ST_SEND, ST_WAIT_ECHO.
- ST_IDLE:
  - req_ready = one-hot winner when enable and any req_valid; otherwise 0.
  - Search starts at rr_ptr+1 and wraps.
  - On transfer (valid & ready), latch event, channel and repeat target (REPEAT_DATA if data-class, else REPEAT_CTRL).
  - Set rr_ptr to the winner, clear echo_seen, go to ST_SEND.
- ST_SEND:
  - slot_valid=1.
  - Each frame_tick increments sent_cnt.
  - When sent_cnt reaches the target: go to ST_IDLE if the event is not data-class or echo_seen=1; otherwise go to ST_WAIT_ECHO.
- ST_WAIT_ECHO:
  - slot_valid=1, same event.
  - Each frame_tick increments to_cnt.
  - Matching echo goes to ST_IDLE.
  - When to_cnt reaches ECHO_TIMEOUT: set err[ch], go to ST_IDLE.
- Matching echo:
  - rx_echo_valid, rx_echo_ch equals the latched channel, and rx_echo_event equals expected_echo(event).
  - Mapping: data_0 to data_0_echo, data_1 to data_1_echo, bit_rcv to data_rcv_echo.
  - A match during ST_SEND sets echo_seen. Non-matching echoes are ignored.
- enable low does not abort an in-flight transaction; it only blocks new grants.
- err: set has priority over err_clr on the same bit in the same cycle.
- Reset values: state ST_IDLE, slot_valid 0, slot_event idle, slot_ch 0, err 0, rr_ptr NUM_CH-1 (channel 0 wins first), counters 0.

## Timing
- Transfer in cycle T: slot_valid/slot_event/slot_ch registered and valid from T+1.
- A frame_tick in cycle T is not counted. Counting starts at T+1.
- Exit to ST_IDLE: slot_valid=0 and slot_event=idle on the next cycle. ST_IDLE lasts at least 1 cycle, so back-to-back grants are at least 2 cycles apart.
- frame_tick and a matching echo in the same ST_WAIT_ECHO cycle: the echo wins and err is not set.
- Tick reaching ECHO_TIMEOUT together with a matching echo: same rule, the echo wins.
- Counter widths: $clog2(max(REPEAT_DATA, ECHO_TIMEOUT)+1). Counters saturate and never wrap.
- reset_n assertion mid-transaction clears everything immediately (asynchronous). A held request is re-granted after release.

## Structure
- ltpi_pkg additions:
  - function is_data_event(smbus_event_t).
  - function expected_echo(smbus_event_t).
  - constants SMBUS_REPEAT_DATA=3 and SMBUS_REPEAT_CTRL=1.
- Sub-module smbus_rr_arbiter:
  - Parameterized NUM_CH.
  - Inputs: req vector, rr_ptr, en.
  - Output: one-hot grant plus encoded index.
  - Purely combinational. The pointer register stays in the parent.

## Test plan
- Single ch0 stop with REPEAT_CTRL=1: ready in T, slot_event=stop from T+1, returns to idle the cycle after 1st tick.
- ch2 data_1 with data_1_echo on ch2 before 3rd tick: slot held exactly 3 ticks, then idle, err=0.
- ch1 bit_rcv with no echo: 3 ticks in ST_SEND, then 16 ticks in ST_WAIT_ECHO, then err[1]=1 and slot idle. err_clr[1] clears it.
- All 4 channels valid continuously: grants in order 0,1,2,3,0. An echo with the wrong channel or event has no effect.
- Matching echo on the same cycle as the 16th ST_WAIT_ECHO tick: err stays 0. err set and err_clr on the same cycle: err stays 1.
- reset_n pulsed low mid-ST_SEND: slot_valid=0 and slot_event=idle asynchronously. After release, ch0 is re-granted first.

Source files
------------

// File: rtl/smbus_event_scheduler_pkg.sv
// smbus_event_scheduler_pkg: SMBus event encoding, scheduler states and echo helpers.
package smbus_event_scheduler_pkg;

    localparam int SMBUS_REPEAT_DATA  = 3;
    localparam int SMBUS_REPEAT_CTRL  = 1;
    localparam int SMBUS_ECHO_TIMEOUT = 16;

    typedef enum logic [3:0] {
        EV_IDLE          = 4'd0,
        EV_START         = 4'd1,
        EV_STOP          = 4'd2,
        EV_DATA_0        = 4'd3,
        EV_DATA_1        = 4'd4,
        EV_BIT_RCV       = 4'd5,
        EV_DATA_0_ECHO   = 4'd6,
        EV_DATA_1_ECHO   = 4'd7,
        EV_DATA_RCV_ECHO = 4'd8,
        EV_ACK           = 4'd9,
        EV_NACK          = 4'd10
    } smbus_event_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_ECHO} sched_state_t;

    function automatic logic is_data_event(smbus_event_t ev);
        return ev == EV_DATA_0 || ev == EV_DATA_1 || ev == EV_BIT_RCV;
    endfunction

    function automatic smbus_event_t expected_echo(smbus_event_t ev);
        return ev == EV_DATA_0  ? EV_DATA_0_ECHO :
               ev == EV_DATA_1  ? EV_DATA_1_ECHO :
               ev == EV_BIT_RCV ? EV_DATA_RCV_ECHO : EV_IDLE;
    endfunction

endpackage

// File: rtl/smbus_event_scheduler_rr_arbiter.sv
// smbus_rr_arbiter: combinational round-robin pick starting after rr_ptr.
module smbus_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
    input  logic                      en,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] idx
);
    localparam int CHW = $clog2(NUM_CH);

    // Walk from farthest to nearest so the channel right after rr_ptr overwrites last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (en && req[(int'(rr_ptr) + i) % NUM_CH]) begin
                gnt = '0;
                gnt[(int'(rr_ptr) + i) % NUM_CH] = 1'b1;
                idx = CHW'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end
endmodule

// File: rtl/smbus_event_scheduler.sv
// smbus_event_scheduler: round-robin share of the LTPI frame SMBus slot with repeat and echo tracking.
module smbus_event_scheduler
    import smbus_event_scheduler_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int REPEAT_DATA  = SMBUS_REPEAT_DATA,
    parameter int REPEAT_CTRL  = SMBUS_REPEAT_CTRL,
    parameter int ECHO_TIMEOUT = SMBUS_ECHO_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      frame_tick,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [4*NUM_CH-1:0]       req_event,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic                      rx_echo_valid,
    input  logic [$clog2(NUM_CH)-1:0] rx_echo_ch,
    input  logic [3:0]                rx_echo_event,
    output logic                      slot_valid,
    output logic [3:0]                slot_event,
    output logic [$clog2(NUM_CH)-1:0] slot_ch,
    output logic [NUM_CH-1:0]         err,
    input  logic [NUM_CH-1:0]         err_clr
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int CW  = $clog2((REPEAT_DATA > ECHO_TIMEOUT ? REPEAT_DATA : ECHO_TIMEOUT) + 1);

    sched_state_t      state;
    logic [CHW-1:0]    rr_ptr, gnt_idx;
    logic [NUM_CH-1:0] gnt, err_set;
    logic [CW-1:0]     target, sent_cnt, to_cnt, sent_nx, to_nx;
    logic [3:0]        gnt_event;
    logic              slot_data, echo_seen, echo_match, send_done, timeout, leave;

    smbus_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .en     (enable && state == ST_IDLE),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    assign req_ready  = gnt;
    assign gnt_event  = req_event[{gnt_idx, 2'b00} +: 4];
    assign slot_data  = is_data_event(smbus_event_t'(slot_event));
    assign echo_match = rx_echo_valid && rx_echo_ch == slot_ch && slot_data &&
                        rx_echo_event == expected_echo(smbus_event_t'(slot_event));
    assign sent_nx    = &sent_cnt ? sent_cnt : sent_cnt + 1'b1;
    assign to_nx      = &to_cnt ? to_cnt : to_cnt + 1'b1;
    assign send_done  = state == ST_SEND && frame_tick && sent_nx >= target;
    // A matching echo always beats the timeout tick.
    assign timeout    = state == ST_WAIT_ECHO && frame_tick && !echo_match && to_nx >= CW'(ECHO_TIMEOUT);
    assign leave      = (send_done && (!slot_data || echo_seen || echo_match)) ||
                        (state == ST_WAIT_ECHO && (echo_match || timeout));
    assign err_set    = timeout ? NUM_CH'(1) << slot_ch : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            slot_valid <= 1'b0;
            slot_event <= EV_IDLE;
            slot_ch    <= '0;
            err        <= '0;
            rr_ptr     <= CHW'(NUM_CH - 1);
            target     <= '0;
            sent_cnt   <= '0;
            to_cnt     <= '0;
            echo_seen  <= 1'b0;
        end else begin
            err <= (err & ~err_clr) | err_set;
            if (state == ST_IDLE && |gnt) begin
                state      <= ST_SEND;
                slot_valid <= 1'b1;
                slot_event <= gnt_event;
                slot_ch    <= gnt_idx;
                target     <= is_data_event(smbus_event_t'(gnt_event)) ? CW'(REPEAT_DATA) : CW'(REPEAT_CTRL);
                rr_ptr     <= gnt_idx;
                sent_cnt   <= '0;
                to_cnt     <= '0;
                echo_seen  <= 1'b0;
            end
            if (state == ST_SEND) begin
                echo_seen <= echo_seen || echo_match;
                sent_cnt  <= frame_tick ? sent_nx : sent_cnt;
            end
            if (state == ST_WAIT_ECHO)
                to_cnt <= frame_tick ? to_nx : to_cnt;
            if (send_done && !leave)
                state <= ST_WAIT_ECHO;
            if (leave) begin
                state      <= ST_IDLE;
                slot_valid <= 1'b0;
                slot_event <= EV_IDLE;
            end
            if (state != ST_IDLE && state != ST_SEND && state != ST_WAIT_ECHO)
                state <= ST_IDLE;
        end
    end
endmodule
